ref_sched: RTL and testbench

// - Refresh scheduler for the gain-cell DRAM array; sits directly upstream of the bank remap table.
// - Periodically picks the next logical data bank and copies it row by row into the spare bank (logical bank 0).
// - On completion, emits a one-cycle any_ref_done plus ref_mem_addr so the remap table swaps that bank with the spare.
// - Obtains array access from the user port through a req/gnt handshake.

---
 rtl/ref_sched.sv | 178 +++++++++++++++++
 tb/tb_ref_sched.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_sched.sv
// ref_sched: refresh scheduler for the gain-cell DRAM array.
// Periodically copies the next logical data bank, row by row, into the spare
// (logical bank 0). Each completed copy is reported with a one-cycle
// any_ref_done and ref_mem_addr so that the downstream remap table can swap
// the copied bank with the spare.
// Optional feature macro: REF_SCHED_STATS_EN adds a saturating 16-bit count
// of completed copies on output ref_cnt.
module ref_sched #(
    parameter int NUM_BANKS  = 8,
    parameter int ADDR_W     = 3,
    parameter int ROW_W      = 4,
    parameter int DATA_W     = 8,
    parameter int REF_PERIOD = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ref_gnt,
    input  logic [DATA_W-1:0] ref_rdata,
    output logic              ref_req,
    output logic              ref_rd_en,
    output logic              ref_wr_en,
    output logic [ADDR_W-1:0] ref_raddr,
    output logic [ADDR_W-1:0] ref_waddr,
    output logic [ROW_W-1:0]  ref_row,
    output logic [DATA_W-1:0] ref_wdata,
    output logic              any_ref_done,
    output logic [ADDR_W-1:0] ref_mem_addr,
    output logic              ref_miss
`ifdef REF_SCHED_STATS_EN
    ,
    output logic [15:0]       ref_cnt
`endif
);

    localparam int                TMR_W      = $clog2(REF_PERIOD);
    localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(REF_PERIOD - 1);
    localparam logic [ADDR_W-1:0] FIRST_BANK = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_BANK  = ADDR_W'(NUM_BANKS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW   = '1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state_q,    state_d;
    logic [TMR_W-1:0]  timer_q,    timer_d;
    logic [ADDR_W-1:0] victim_q,   victim_d;
    logic [ROW_W-1:0]  row_q,      row_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              pending_q,  pending_d;
    logic              miss_q,     miss_d;
    logic              req_q,      req_d;
    logic              done_q,     done_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              trig;

    // Next-state logic: refresh timer, pending/miss tracking and the copy FSM.
    always_comb begin
        trig       = (timer_q == '0);
        timer_d    = trig ? TMR_RELOAD : timer_q - TMR_W'(1);
        state_d    = state_q;
        row_d      = row_q;
        victim_d   = victim_q;
        wdata_d    = wdata_q;
        pending_d  = pending_q;
        miss_d     = miss_q | (trig & pending_q);

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    state_d   = REQ;
                    pending_d = 1'b0;
                end
            end
            REQ: begin
                if (ref_gnt) state_d = RD;
            end
            RD: begin
                // Without grant the read did not happen; stay and retry.
                if (ref_gnt) begin
                    state_d = WR;
                    wdata_d = ref_rdata;
                end
            end
            WR: begin
                if (ref_gnt) begin
                    if (row_q == LAST_ROW) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = RD;
                    end
                end else begin
                    // The user port may have touched the row meanwhile, so
                    // the captured data is stale: read the row again.
                    state_d = RD;
                end
            end
            DONE: begin
                state_d  = IDLE;
                row_d    = '0;
                victim_d = (victim_q == LAST_BANK) ? FIRST_BANK
                                                   : victim_q + ADDR_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // A new trigger wins over the clear done on leaving IDLE.
        if (trig) pending_d = 1'b1;

        req_d      = (state_d == REQ) || (state_d == RD) || (state_d == WR);
        done_d     = (state_d == DONE);
        mem_addr_d = (state_d == DONE) ? victim_q : '0;
    end

    // State, datapath and registered control outputs; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            timer_q    <= TMR_RELOAD;
            victim_q   <= FIRST_BANK;
            row_q      <= '0;
            wdata_q    <= '0;
            pending_q  <= 1'b0;
            miss_q     <= 1'b0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            victim_q   <= victim_d;
            row_q      <= row_d;
            wdata_q    <= wdata_d;
            pending_q  <= pending_d;
            miss_q     <= miss_d;
            req_q      <= req_d;
            done_q     <= done_d;
            mem_addr_q <= mem_addr_d;
        end
    end

`ifdef REF_SCHED_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Saturating count of completed copies.
    always_comb begin
        cnt_d = cnt_q;
        if (done_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    // Completed-copy counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

    assign ref_cnt = cnt_q;
`endif

    // Strobes are gated by the live grant so a lost grant suppresses them
    // in the same cycle.
    assign ref_rd_en    = (state_q == RD) & ref_gnt;
    assign ref_wr_en    = (state_q == WR) & ref_gnt;
    assign ref_req      = req_q;
    assign ref_raddr    = victim_q;
    assign ref_waddr    = '0;
    assign ref_row      = row_q;
    assign ref_wdata    = wdata_q;
    assign any_ref_done = done_q;
    assign ref_mem_addr = mem_addr_q;
    assign ref_miss     = miss_q;

endmodule

// File: tb/tb_ref_sched.sv
// Testbench for ref_sched: directed vectors with hand-computed expectations.
module tb_ref_sched;

    localparam int NUM_BANKS  = 8;
    localparam int ADDR_W     = 3;
    localparam int ROW_W      = 4;
    localparam int DATA_W     = 8;
    localparam int REF_PERIOD = 256;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              ref_gnt = 1'b0;
    logic [DATA_W-1:0] ref_rdata;
    logic              ref_req, ref_rd_en, ref_wr_en;
    logic [ADDR_W-1:0] ref_raddr, ref_waddr;
    logic [ROW_W-1:0]  ref_row;
    logic [DATA_W-1:0] ref_wdata;
    logic              any_ref_done;
    logic [ADDR_W-1:0] ref_mem_addr;
    logic              ref_miss;
`ifdef REF_SCHED_STATS_EN
    logic [15:0]       ref_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int rd_rows[$];
    int wr_rows[$];
    int done_addr[$];
    int done_cyc[$];

    always #5 clk = ~clk;

    // Array model: the row data is a fixed function of the row address.
    assign ref_rdata = DATA_W'(3 * int'(ref_row));

    ref_sched #(
        .NUM_BANKS (NUM_BANKS),
        .ADDR_W    (ADDR_W),
        .ROW_W     (ROW_W),
        .DATA_W    (DATA_W),
        .REF_PERIOD(REF_PERIOD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ref_gnt     (ref_gnt),
        .ref_rdata   (ref_rdata),
        .ref_req     (ref_req),
        .ref_rd_en   (ref_rd_en),
        .ref_wr_en   (ref_wr_en),
        .ref_raddr   (ref_raddr),
        .ref_waddr   (ref_waddr),
        .ref_row     (ref_row),
        .ref_wdata   (ref_wdata),
        .any_ref_done(any_ref_done),
        .ref_mem_addr(ref_mem_addr),
        .ref_miss    (ref_miss)
`ifdef REF_SCHED_STATS_EN
        ,
        .ref_cnt     (ref_cnt)
`endif
    );

    // Cycle number k = number of rising edges since reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Continuous monitor: log strobes and completions, check write data.
    always @(negedge clk) begin
        if (rst) begin
            if (ref_rd_en) rd_rows.push_back(int'(ref_row));
            if (ref_wr_en) begin
                wr_rows.push_back(int'(ref_row));
                chk("wdata", 32'(ref_wdata), 32'(3 * int'(ref_row)));
                chk("waddr", 32'(ref_waddr), 0);
            end
            if (!ref_gnt) chk("strobe_while_gnt_low", {30'd0, ref_rd_en, ref_wr_en}, 0);
            if (any_ref_done) begin
                done_addr.push_back(int'(ref_mem_addr));
                done_cyc.push_back(cyc);
                chk("mem_addr_nonzero", 32'(ref_mem_addr != 0), 1);
            end
        end
    end

    task automatic clear_logs();
        rd_rows.delete();
        wr_rows.delete();
        done_addr.delete();
        done_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},      32'(ref_req), 0);
        chk({tag, "_rd_en"},    32'(ref_rd_en), 0);
        chk({tag, "_wr_en"},    32'(ref_wr_en), 0);
        chk({tag, "_raddr"},    32'(ref_raddr), 1);
        chk({tag, "_waddr"},    32'(ref_waddr), 0);
        chk({tag, "_row"},      32'(ref_row), 0);
        chk({tag, "_wdata"},    32'(ref_wdata), 0);
        chk({tag, "_done"},     32'(any_ref_done), 0);
        chk({tag, "_mem_addr"}, 32'(ref_mem_addr), 0);
        chk({tag, "_miss"},     32'(ref_miss), 0);
`ifdef REF_SCHED_STATS_EN
        chk({tag, "_cnt"},      32'(ref_cnt), 0);
`endif
    endtask

    task automatic reset_dut(input logic gnt);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ref_gnt = gnt;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_dones(input int n, input int budget, input string name);
        int k;
        k = 0;
        while ((done_addr.size() < n) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        if (done_addr.size() < n) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_rd_row(input int r, input int budget, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!(ref_rd_en && (int'(ref_row) == r)) && (k < budget)) begin
            @(negedge clk);
            k++;
        end
        if (!(ref_rd_en && (int'(ref_row) == r))) chk({name, "_timeout"}, 0, 1);
    endtask

    typedef struct {
        int   cyc;
        logic req;
        logic rd;
        logic wr;
        int   row;
        logic done;
        int   mem_addr;
        int   raddr;
    } vec_t;

    vec_t tbl[11];
    int   exp_seq[8];
    int   n7;
    int   idx;

    initial begin
        // First copy after reset, grant held high.
        tbl[0]  = '{255, 1'b0, 1'b0, 1'b0,  0, 1'b0, 0, 1};
        tbl[1]  = '{256, 1'b0, 1'b0, 1'b0,  0, 1'b0, 0, 1};
        tbl[2]  = '{257, 1'b1, 1'b0, 1'b0,  0, 1'b0, 0, 1};
        tbl[3]  = '{258, 1'b1, 1'b1, 1'b0,  0, 1'b0, 0, 1};
        tbl[4]  = '{259, 1'b1, 1'b0, 1'b1,  0, 1'b0, 0, 1};
        tbl[5]  = '{260, 1'b1, 1'b1, 1'b0,  1, 1'b0, 0, 1};
        tbl[6]  = '{275, 1'b1, 1'b0, 1'b1,  8, 1'b0, 0, 1};
        tbl[7]  = '{288, 1'b1, 1'b1, 1'b0, 15, 1'b0, 0, 1};
        tbl[8]  = '{289, 1'b1, 1'b0, 1'b1, 15, 1'b0, 0, 1};
        tbl[9]  = '{290, 1'b0, 1'b0, 1'b0, 15, 1'b1, 1, 1};
        tbl[10] = '{291, 1'b0, 1'b0, 1'b0,  0, 1'b0, 0, 2};
        exp_seq = '{1, 2, 3, 4, 5, 6, 7, 1};

        // Reset state while rst is held low.
        ref_gnt = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        clear_logs();

        // Table-driven first copy.
        for (int i = 0; i < 11; i++) begin
            at_cycle(tbl[i].cyc);
            chk($sformatf("t%0d_req", tbl[i].cyc),      32'(ref_req),      32'(tbl[i].req));
            chk($sformatf("t%0d_rd_en", tbl[i].cyc),    32'(ref_rd_en),    32'(tbl[i].rd));
            chk($sformatf("t%0d_wr_en", tbl[i].cyc),    32'(ref_wr_en),    32'(tbl[i].wr));
            chk($sformatf("t%0d_row", tbl[i].cyc),      32'(ref_row),      32'(tbl[i].row));
            chk($sformatf("t%0d_done", tbl[i].cyc),     32'(any_ref_done), 32'(tbl[i].done));
            chk($sformatf("t%0d_mem_addr", tbl[i].cyc), 32'(ref_mem_addr), 32'(tbl[i].mem_addr));
            chk($sformatf("t%0d_raddr", tbl[i].cyc),    32'(ref_raddr),    32'(tbl[i].raddr));
        end
        chk("copy1_wr_count", 32'(wr_rows.size()), 16);
        chk("copy1_rd_count", 32'(rd_rows.size()), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < wr_rows.size()) chk($sformatf("copy1_wr_row%0d", i), 32'(wr_rows[i]), 32'(i));
            if (i < rd_rows.size()) chk($sformatf("copy1_rd_row%0d", i), 32'(rd_rows[i]), 32'(i));
        end

        // Eight refreshes: victim rotates 1..7 and skips the spare.
        wait_dones(8, 2200, "eight_refresh");
        for (int i = 0; i < 8; i++)
            if (i < done_addr.size()) chk($sformatf("victim_seq%0d", i), 32'(done_addr[i]), 32'(exp_seq[i]));
        repeat (2) @(negedge clk);
        chk("no_miss_with_gnt", 32'(ref_miss), 0);
`ifdef REF_SCHED_STATS_EN
        chk("cnt_after_8", 32'(ref_cnt), 8);
`endif

        // Starved grant: miss becomes sticky, then two back-to-back copies.
        reset_dut(1'b0);
        at_cycle(800);
        chk("starved_miss", 32'(ref_miss), 1);
        chk("starved_req", 32'(ref_req), 1);
        chk("starved_no_done", 32'(done_addr.size()), 0);
        @(posedge clk);
        #1 ref_gnt = 1'b1;
        wait_dones(2, 200, "backlog");
        if (done_addr.size() >= 2) begin
            chk("backlog_bank_a", 32'(done_addr[0]), 1);
            chk("backlog_bank_b", 32'(done_addr[1]), 2);
            chk("backlog_gap", 32'(done_cyc[1] - done_cyc[0]), 35);
        end
        chk("miss_sticky", 32'(ref_miss), 1);

        // Grant dropped for 5 cycles while row 7 is in its write cycle.
        reset_dut(1'b1);
        wait_rd_row(7, 600, "gnt_drop_find");
        @(posedge clk);
        #1 ref_gnt = 1'b0;
        repeat (5) @(posedge clk);
        #1 ref_gnt = 1'b1;
        wait_dones(1, 100, "gnt_drop_done");
        chk("drop_wr_count", 32'(wr_rows.size()), 16);
        chk("drop_rd_count", 32'(rd_rows.size()), 17);
        for (int i = 0; i < 16; i++)
            if (i < wr_rows.size()) chk($sformatf("drop_wr_row%0d", i), 32'(wr_rows[i]), 32'(i));
        n7 = 0;
        idx = 0;
        foreach (rd_rows[i]) if (rd_rows[i] == 7) n7++;
        chk("drop_row7_reads", 32'(n7), 2);
        for (int i = 0; i < rd_rows.size(); i++) begin
            chk($sformatf("drop_rd_seq%0d", i), 32'(rd_rows[i]), 32'(idx));
            if (i != 7) idx++;
        end

        // Mid-copy reset at row 9 of the second copy (bank 2).
        reset_dut(1'b1);
        wait_dones(1, 400, "midrst_first");
        wait_rd_row(9, 400, "midrst_find");
        chk("midrst_victim_before", 32'(ref_raddr), 2);
        rst = 1'b0;
        #2;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_logs();
        wait_rd_row(0, 400, "midrst_restart");
        chk("midrst_restart_row", 32'(ref_row), 0);
        chk("midrst_restart_bank", 32'(ref_raddr), 1);
        chk("midrst_no_swap", 32'(done_addr.size()), 0);
        wait_dones(1, 100, "midrst_done");
        if (done_addr.size() >= 1) chk("midrst_done_bank", 32'(done_addr[0]), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
